// File: rtl/m_trig_pkg.sv
// Shared types and constants for the slope trigger: FSM states, mode codes
// and the helper that maps a mode onto the positive/negative flags.
package m_trig_pkg;

  localparam int MAX_LAG = 16;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_ARMED,
    ST_HOLDOFF
  } state_t;

  function automatic logic mode_cond(input logic [1:0] mode,
                                     input logic       pos,
                                     input logic       neg);
    return ((mode == MODE_RISE || mode == MODE_BOTH) && pos) ||
           ((mode == MODE_FALL || mode == MODE_BOTH) && neg);
  endfunction

endpackage

// File: rtl/m_delay_line.sv
// Synchronous-clear shift register; dout is din delayed by DEPTH cycles.
module m_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/m_slope_trigger.sv
// Lagged-difference slope detector feeding an arm/holdoff trigger FSM.
// Define M_SLOPE_TRIGGER_HYST_EN to hold HOLDOFF until the slope condition clears.
module m_slope_trigger
  import m_trig_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LAG       = 1,
  parameter int POS_VALUE = 8,
  parameter int NEG_VALUE = 8,
  parameter int HOLDOFF_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [1:0]           mode,
  input  logic                 arm,
  input  logic [HOLDOFF_W-1:0] holdoff,
  output logic [WIDTH-1:0]     out,
  output logic signed [WIDTH:0] delta,
  output logic                 positive,
  output logic                 negative,
  output logic                 trig,
  output logic                 armed
);

  localparam int FILL_W = $clog2(MAX_LAG + 2);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LAG + 1);
  localparam logic signed [WIDTH:0] POS_TH = (WIDTH+1)'(POS_VALUE);
  localparam logic signed [WIDTH:0] NEG_TH = -((WIDTH+1)'(NEG_VALUE));

  logic [WIDTH-1:0]     s0;
  logic [WIDTH-1:0]     hist;
  logic signed [WIDTH:0] delta_c;
  logic [FILL_W-1:0]    fill_cnt;
  logic                 fill_done;
  logic                 cond;
  logic                 release_ok;
  state_t               state;
  logic [HOLDOFF_W-1:0] hold_cnt;

  m_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (LAG)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (s0),
    .dout  (hist)
  );

  // Zero-extended operands keep the full +/-(2^WIDTH-1) range without overflow.
  assign delta_c   = $signed({1'b0, s0}) - $signed({1'b0, hist});
  assign fill_done = (fill_cnt == FILL_MAX);
  assign cond      = mode_cond(mode, positive, negative);

`ifdef M_SLOPE_TRIGGER_HYST_EN
  assign release_ok = !cond;
`else
  assign release_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0       <= '0;
      out      <= '0;
      delta    <= '0;
      positive <= 1'b0;
      negative <= 1'b0;
      fill_cnt <= '0;
    end else begin
      s0       <= in;
      out      <= s0;
      delta    <= delta_c;
      positive <= (delta_c > POS_TH);
      negative <= (delta_c < NEG_TH);
      if (!fill_done) fill_cnt <= fill_cnt + FILL_W'(1);
    end
  end

  // The FSM reacts to the registered flags, giving the 3-cycle in-to-trig latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      trig     <= 1'b0;
      armed    <= 1'b0;
    end else begin
      trig  <= 1'b0;
      armed <= 1'b0;
      if (mode == MODE_OFF) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:    if (arm) state <= ST_FILL;
          ST_FILL:    if (fill_done) state <= ST_ARMED;
          ST_ARMED: begin
            if (cond) begin
              trig     <= 1'b1;
              hold_cnt <= holdoff;
              state    <= ST_HOLDOFF;
            end else begin
              armed <= 1'b1;
            end
          end
          ST_HOLDOFF: begin
            if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLDOFF_W'(1);
            else if (release_ok) state <= ST_ARMED;
          end
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/m_slope_trigger.md
# m_slope_trigger

Parametrised slope trigger for the acquisition path, the next generation of the slope finder. It compares each ADC sample with the sample LAG cycles earlier and flags positive and negative slopes against separate thresholds. An arm/holdoff state machine turns those flags into a single-cycle trigger pulse. It sits between the ADC capture register and the capture-control logic.

## Interface
- WIDTH, 8: sample width (unsigned).
- LAG, 1: compare distance in samples, 1..16.
- POS_VALUE, 8: positive threshold, 0..2^WIDTH-1.
- NEG_VALUE, 8: negative threshold, 0..2^WIDTH-1.
- HOLDOFF_W, 8: holdoff counter width.

- clk  in  1  sample clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in  in  WIDTH  ADC sample, one per cycle.
- mode  in  2  00 off, 01 rising, 10 falling, 11 either.
- arm  in  1  arm request, sampled each cycle.
- holdoff  in  HOLDOFF_W  holdoff length, sampled at trigger.
- out  out  WIDTH  sample aligned with delta.
- delta  out  WIDTH+1  signed (s0 - s0 delayed LAG).
- positive  out  1  delta > POS_VALUE (signed, strict).
- negative  out  1  delta < -NEG_VALUE (signed, strict).
- trig  out  1  one-cycle trigger pulse.
- armed  out  1  high while in ARMED.

## Operation
- Stage 1: s0 <= in. The delay line shifts every cycle.
- Stage 2: registers out <= s0, delta, positive and negative.
- delta is computed as {1'b0,s0} - {1'b0,hist[LAG]} in WIDTH+1 bits. Its range is ±(2^WIDTH-1), so there is no overflow. positive and negative are mutually exclusive.
- Fill counter:
  - Counts cycles after reset and saturates at LAG+1.
  - fill_done is high when the counter is saturated.
- States are IDLE, FILL, ARMED and HOLDOFF.
  - IDLE: arm=1 and mode!=00 goes to FILL.
  - FILL: goes to ARMED once fill_done is high.
  - ARMED: the condition is positive for mode 01, negative for mode 10, and either for mode 11. When it is met, trig <= 1, the counter loads holdoff, and the state goes to HOLDOFF.
  - HOLDOFF: decrements the counter and goes to ARMED when the counter is 0. A holdoff of 0 therefore gives 1 cycle in HOLDOFF.
- mode==00 in any state forces IDLE on the next cycle. trig is not issued in that cycle.
- arm outside IDLE is ignored. Re-arming is automatic after holdoff.
- Reset values:
  - out, delta, positive, negative, trig and armed are all 0.
  - The delay line and fill counter are cleared, and the state is IDLE.
- Reset mid-operation aborts immediately. A fresh fill is required before the block can trigger again.

## Timing
- Latency from in to out/delta/positive/negative is 2 cycles.
- Latency from in to trig is 3 cycles.
- armed goes high 1 cycle after the state enters ARMED, and falls in the same cycle trig rises.
- Minimum spacing between trig pulses is holdoff+2 cycles.
- Boundary: a slope present on the cycle ARMED is entered can trigger immediately.
- Boundary: a condition true only during HOLDOFF is discarded, not queued.

## Configuration
- Macro: M_SLOPE_TRIGGER_HYST_EN.
- Defined: leaving HOLDOFF additionally requires the condition flags for the current mode to be low for at least one cycle. HOLDOFF is held until that happens, so one long slope yields one trigger.
- Undefined: re-arm depends on holdoff expiry only.

## Structure
- Package m_trig_pkg holds:
  - the state enum;
  - the mode constants MODE_OFF, MODE_RISE, MODE_FALL and MODE_BOTH;
  - a MAX_LAG=16 constant.
- Sub-module m_delay_line(WIDTH, DEPTH) provides the synchronous-clear shift register that gives hist[LAG].

## Test plan
All cases use WIDTH=8, LAG=1, POS=8, NEG=8.
- Reset: rst_n=0 for 3 cycles with in=200 -> all outputs 0, armed=0, and no trig for LAG+1 cycles after release.
- Rising trigger: mode=01, holdoff=4, arm pulse after 4 samples of 10, then 12,32,72,12,15,18.
  - delta = 2,20,40,-60,3,3.
  - positive is high for the 32 and 72 samples.
  - Exactly one trig, 3 cycles after 32 is applied.
  - armed returns high 6 cycles after trig.
- Falling and either modes on the same sequence:
  - mode=10 gives one trig on 12 (delta -60).
  - mode=11 with holdoff=0 gives trig on 32 and on 12 only. 72 falls inside HOLDOFF.
- Threshold edge: deltas of exactly +8 and -8 give no flags. +9 and -9 give positive and negative respectively.
- Mode off and re-arm:
  - mode=00 during HOLDOFF -> IDLE next cycle.
  - A subsequent arm re-enters ARMED with no spurious trig.
- With M_SLOPE_TRIGGER_HYST_EN and holdoff=0: a ramp of +20 per sample for 10 cycles gives exactly 1 trig. Without the macro it gives one trig every 2 cycles.
